// File: rtl/fractional_adder.sv
// Registered Q0.DATA_WIDTH fraction adder/subtractor with carry/borrow flag.
// One-cycle latency; outputs come only from registers.
module fractional_adder #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter bit          SATURATE   = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic                  sub,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] Out,
    output logic                  overflow
);

    logic [DATA_WIDTH:0]   inter;
    logic                  inter_ov;
    logic [DATA_WIDTH-1:0] result;

    logic [DATA_WIDTH-1:0] out_q, out_d;
    logic                  ovf_q, ovf_d;
    logic                  vld_q, vld_d;

    // The top bit of the widened result is the carry on add and the borrow on subtract.
    always_comb begin
        if (sub) begin
            inter = {1'b0, A} - {1'b0, B};
        end else begin
            inter = {1'b0, A} + {1'b0, B};
        end
        inter_ov = inter[DATA_WIDTH];
    end

    always_comb begin
        result = inter[DATA_WIDTH-1:0];
        if (SATURATE && inter_ov) begin
            result = sub ? '0 : '1;
        end
    end

    always_comb begin
        out_d = out_q;
        ovf_d = ovf_q;
        vld_d = 1'b0;
        if (in_valid) begin
            out_d = result;
            ovf_d = inter_ov;
            vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q <= '0;
            ovf_q <= 1'b0;
            vld_q <= 1'b0;
        end else begin
            out_q <= out_d;
            ovf_q <= ovf_d;
            vld_q <= vld_d;
        end
    end

    assign Out       = out_q;
    assign overflow  = ovf_q;
    assign out_valid = vld_q;

endmodule

// File: tb/tb_fractional_adder.sv
// Bench for fractional_adder: wrap and saturate instances side by side,
// directed vector table, streaming/reset sequences and random traffic.
module tb_fractional_adder;

    localparam int unsigned W = 8;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic         sub;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         vld0, vld1, ovf0, ovf1;
    logic [W-1:0] out0, out1;

    int checks = 0;
    int errors = 0;

    fractional_adder #(.DATA_WIDTH(W), .SATURATE(1'b0)) dut_wrap (
        .clk(clk), .reset(reset), .in_valid(in_valid), .sub(sub), .A(A), .B(B),
        .out_valid(vld0), .Out(out0), .overflow(ovf0)
    );

    fractional_adder #(.DATA_WIDTH(W), .SATURATE(1'b1)) dut_sat (
        .clk(clk), .reset(reset), .in_valid(in_valid), .sub(sub), .A(A), .B(B),
        .out_valid(vld1), .Out(out1), .overflow(ovf1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit           s;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_wrap;
        logic         exp_ov;
        logic [W-1:0] exp_sat;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input logic ev, input logic [W-1:0] ew, input logic eo,
                             input logic [W-1:0] es);
        chk("out_valid_wrap", {7'd0, vld0}, {7'd0, ev});
        chk("out_valid_sat",  {7'd0, vld1}, {7'd0, ev});
        chk("out_wrap",       out0, ew);
        chk("overflow_wrap",  {7'd0, ovf0}, {7'd0, eo});
        chk("out_sat",        out1, es);
        chk("overflow_sat",   {7'd0, ovf1}, {7'd0, eo});
    endtask

    task automatic step(input bit r, input bit v, input bit s, input logic [W-1:0] a,
                        input logic [W-1:0] b);
        @(negedge clk);
        reset    = r;
        in_valid = v;
        sub      = s;
        A        = a;
        B        = b;
        @(posedge clk);
        #1;
    endtask

    // Exact arithmetic on integers, then mapped to the two result policies.
    task automatic model(input bit s, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] w, output logic o, output logic [W-1:0] sat);
        int r;
        r   = s ? (int'(a) - int'(b)) : (int'(a) + int'(b));
        o   = (r < 0) || (r > 255);
        w   = W'(r & 255);
        sat = !o ? W'(r) : (s ? 8'h00 : 8'hFF);
    endtask

    initial begin
        logic [W-1:0] ew, es;
        logic         eo, ev;
        bit           r, v, s;
        logic [W-1:0] a, b;

        reset = 1'b1; in_valid = 1'b0; sub = 1'b0; A = '0; B = '0;

        vecs[0] = '{1'b0, 8'h40, 8'h20, 8'h60, 1'b0, 8'h60};
        vecs[1] = '{1'b0, 8'hA0, 8'h20, 8'hC0, 1'b0, 8'hC0};
        vecs[2] = '{1'b0, 8'h20, 8'h60, 8'h80, 1'b0, 8'h80};
        vecs[3] = '{1'b0, 8'hC0, 8'h40, 8'h00, 1'b1, 8'hFF};
        vecs[4] = '{1'b1, 8'h60, 8'h20, 8'h40, 1'b0, 8'h40};
        vecs[5] = '{1'b1, 8'h20, 8'h40, 8'hE0, 1'b1, 8'h00};
        vecs[6] = '{1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 8'hFF};
        vecs[7] = '{1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00};
        vecs[8] = '{1'b0, 8'hFF, 8'h00, 8'hFF, 1'b0, 8'hFF};

        step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        check_all(1'b0, 8'h00, 1'b0, 8'h00);

        for (int i = 0; i < 9; i++) begin
            step(1'b0, 1'b1, vecs[i].s, vecs[i].a, vecs[i].b);
            check_all(1'b1, vecs[i].exp_wrap, vecs[i].exp_ov, vecs[i].exp_sat);
        end

        // Reset with a valid operation: the operation is dropped.
        step(1'b0, 1'b1, 1'b0, 8'h30, 8'h10);
        check_all(1'b1, 8'h40, 1'b0, 8'h40);
        step(1'b1, 1'b1, 1'b0, 8'hFF, 8'h01);
        check_all(1'b0, 8'h00, 1'b0, 8'h00);

        // Three back-to-back results, then hold on idle.
        step(1'b0, 1'b1, 1'b0, 8'h10, 8'h20);
        check_all(1'b1, 8'h30, 1'b0, 8'h30);
        step(1'b0, 1'b1, 1'b1, 8'h10, 8'h20);
        check_all(1'b1, 8'hF0, 1'b1, 8'h00);
        step(1'b0, 1'b1, 1'b0, 8'h80, 8'h05);
        check_all(1'b1, 8'h85, 1'b0, 8'h85);
        step(1'b0, 1'b0, 1'b1, 8'h77, 8'hEE);
        check_all(1'b0, 8'h85, 1'b0, 8'h85);
        step(1'b0, 1'b0, 1'b0, 8'hFF, 8'hFF);
        check_all(1'b0, 8'h85, 1'b0, 8'h85);

        ev = 1'b0; ew = 8'h85; eo = 1'b0; es = 8'h85;
        for (int n = 0; n < 300; n++) begin
            logic [W-1:0] tw, ts;
            logic         to;
            r = ($urandom_range(0, 19) == 0);
            v = ($urandom_range(0, 3) != 0);
            s = $urandom_range(0, 1) == 1;
            a = W'($urandom);
            b = W'($urandom);
            step(r, v, s, a, b);
            if (r) begin
                ev = 1'b0; ew = '0; eo = 1'b0; es = '0;
            end else if (v) begin
                model(s, a, b, tw, to, ts);
                ev = 1'b1; ew = tw; eo = to; es = ts;
            end else begin
                ev = 1'b0;
            end
            check_all(ev, ew, eo, es);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
